// File: rtl/sound_latch_bridge_if.sv
// ============================================================================
//  Module      : sound_latch_bridge_if
//  Description : M68K / Z80 sound-latch bus bundle. The master side is the
//                system (CPU buses and chip-select decode). The slave side is
//                the sound latch bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sound_latch_bridge_if;
    // M68K side
    logic        m68k_latch_cs;
    logic        m68k_sound_cs;
    logic        m68k_lds_n;
    logic [15:0] m68k_din;
    logic [15:0] m68k_dout;
    // Z80 side
    logic        z80_latch_cs;
    logic        z80_rd_n;
    logic        z80_wr_n;
    logic [7:0]  z80_dout;
    logic        z80_nmi_n;
    // status / debug
    logic        pending;

    modport master (
        output m68k_latch_cs, m68k_sound_cs, m68k_lds_n, m68k_din,
        output z80_latch_cs, z80_rd_n, z80_wr_n,
        input  m68k_dout, z80_dout, z80_nmi_n, pending
    );

    modport slave (
        input  m68k_latch_cs, m68k_sound_cs, m68k_lds_n, m68k_din,
        input  z80_latch_cs, z80_rd_n, z80_wr_n,
        output m68k_dout, z80_dout, z80_nmi_n, pending
    );
endinterface

`default_nettype wire

// File: rtl/sound_latch_bridge.sv
// ============================================================================
//  Module      : sound_latch_bridge
//  Description : M68K -> Z80 sound command latch. It captures the command
//                byte, raises a fixed-width Z80 NMI pulse, and tracks the
//                pending and overrun flags. It also serves the M68K status
//                word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sound_latch_bridge #(
    parameter int NMI_CYCLES    = 16,    // NMI low width in clk cycles, 1..255
    parameter bit CLEAR_ON_READ = 1'b0   // Z80 latch read also clears pending
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    sound_latch_bridge_if.slave  bus
);

    localparam logic [7:0] c_nmi_load = 8'(NMI_CYCLES);

    // Qualified strobe levels
    logic w_m68k_wr_lvl;
    logic w_m68k_rd_lvl;
    logic w_z80_rd_lvl;
    logic w_z80_wr_lvl;

    // Strobe history, used for rising-edge detection
    logic r_m68k_wr_hist;
    logic r_m68k_rd_hist;
    logic r_z80_rd_hist;
    logic r_z80_wr_hist;

    // Single-cycle events
    logic w_m68k_wr_ev;
    logic w_m68k_rd_ev;
    logic w_z80_rd_ev;
    logic w_z80_wr_ev;
    logic w_clear;

    // State
    logic [7:0] r_latch;
    logic       r_pending;
    logic       r_overrun;
    logic [7:0] r_nmi_cnt;
    logic [7:0] w_nmi_cnt_next;
    logic       r_nmi_n;

    // Only the low byte of the M68K bus carries the command
    logic w_unused_din;
    assign w_unused_din = &{1'b0, bus.m68k_din[15:8]};

    // An upper-byte-only write (lds_n high) must not count as a latch write
    assign w_m68k_wr_lvl = bus.m68k_latch_cs & ~bus.m68k_lds_n;
    assign w_m68k_rd_lvl = bus.m68k_sound_cs;
    assign w_z80_rd_lvl  = bus.z80_latch_cs & ~bus.z80_rd_n;
    assign w_z80_wr_lvl  = bus.z80_latch_cs & ~bus.z80_wr_n;

    assign w_m68k_wr_ev = w_m68k_wr_lvl & ~r_m68k_wr_hist;
    assign w_m68k_rd_ev = w_m68k_rd_lvl & ~r_m68k_rd_hist;
    assign w_z80_rd_ev  = w_z80_rd_lvl  & ~r_z80_rd_hist;
    assign w_z80_wr_ev  = w_z80_wr_lvl  & ~r_z80_wr_hist;

    assign w_clear = w_z80_wr_ev | (CLEAR_ON_READ & w_z80_rd_ev);

    // Remember the previous strobe levels so a held strobe gives one event
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_m68k_wr_hist <= 1'b0;
            r_m68k_rd_hist <= 1'b0;
            r_z80_rd_hist  <= 1'b0;
            r_z80_wr_hist  <= 1'b0;
        end else begin
            r_m68k_wr_hist <= w_m68k_wr_lvl;
            r_m68k_rd_hist <= w_m68k_rd_lvl;
            r_z80_rd_hist  <= w_z80_rd_lvl;
            r_z80_wr_hist  <= w_z80_wr_lvl;
        end
    end

    // Capture the command byte on each M68K latch write
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_latch <= 8'h00;
        end else if (w_m68k_wr_ev) begin
            r_latch <= bus.m68k_din[7:0];
        end
    end

    // Pending and overrun flags. An M68K write takes priority over any clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_m68k_wr_ev) begin
                r_pending <= 1'b1;
            end else if (w_clear) begin
                r_pending <= 1'b0;
            end

            if (w_m68k_wr_ev && r_pending) begin
                r_overrun <= 1'b1;
            end else if (w_m68k_rd_ev) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Next NMI count: a write (re)loads it, otherwise it counts down to zero
    always_comb begin
        w_nmi_cnt_next = r_nmi_cnt;
        if (w_m68k_wr_ev) begin
            w_nmi_cnt_next = c_nmi_load;
        end else if (r_nmi_cnt != 8'd0) begin
            w_nmi_cnt_next = r_nmi_cnt - 8'd1;
        end
    end

    // NMI counter and registered active-low NMI output
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_nmi_cnt <= 8'd0;
            r_nmi_n   <= 1'b1;
        end else begin
            r_nmi_cnt <= w_nmi_cnt_next;
            r_nmi_n   <= (w_nmi_cnt_next == 8'd0);
        end
    end

    assign bus.z80_dout  = r_latch;
    assign bus.m68k_dout = {8'h00, 6'b000000, r_overrun, r_pending};
    assign bus.z80_nmi_n = r_nmi_n;
    assign bus.pending   = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_sound_latch_bridge.sv
// ============================================================================
//  Module      : tb_sound_latch_bridge
//  Description : Self-checking bench for sound_latch_bridge. It runs two
//                instances with the same inputs, one with CLEAR_ON_READ=0
//                and one with CLEAR_ON_READ=1, against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sound_latch_bridge;

    localparam int NMI_W = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sound_latch_bridge_if bus0 ();
    sound_latch_bridge_if bus1 ();

    // Instance 1 sees exactly the same stimulus as instance 0
    assign bus1.m68k_latch_cs = bus0.m68k_latch_cs;
    assign bus1.m68k_sound_cs = bus0.m68k_sound_cs;
    assign bus1.m68k_lds_n    = bus0.m68k_lds_n;
    assign bus1.m68k_din      = bus0.m68k_din;
    assign bus1.z80_latch_cs  = bus0.z80_latch_cs;
    assign bus1.z80_rd_n      = bus0.z80_rd_n;
    assign bus1.z80_wr_n      = bus0.z80_wr_n;

    sound_latch_bridge #(.NMI_CYCLES(NMI_W), .CLEAR_ON_READ(1'b0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    sound_latch_bridge #(.NMI_CYCLES(NMI_W), .CLEAR_ON_READ(1'b1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model. The NMI is modelled as a deadline: the output is
    // low while the cycle index is below the last write's cycle + width.
    // ------------------------------------------------------------------
    int         cyc       = 0;
    int         nmi_until = 0;
    logic [7:0] m_latch   = 8'h00;
    logic       m_pend [2];
    logic       m_ovr  [2];
    logic       p_mw = 1'b0, p_mr = 1'b0, p_zr = 1'b0, p_zw = 1'b0;
    logic       l_mw, l_mr, l_zr, l_zw, e_mw, e_mr, e_zr, e_zw, clr;

    initial begin
        m_pend = '{1'b0, 1'b0};
        m_ovr  = '{1'b0, 1'b0};
    end

    always @(posedge clk) begin
        cyc++;
        l_mw = bus0.m68k_latch_cs & ~bus0.m68k_lds_n;
        l_mr = bus0.m68k_sound_cs;
        l_zr = bus0.z80_latch_cs & ~bus0.z80_rd_n;
        l_zw = bus0.z80_latch_cs & ~bus0.z80_wr_n;
        if (!reset_n) begin
            m_latch   = 8'h00;
            nmi_until = 0;
            m_pend    = '{1'b0, 1'b0};
            m_ovr     = '{1'b0, 1'b0};
            p_mw = 1'b0; p_mr = 1'b0; p_zr = 1'b0; p_zw = 1'b0;
        end else begin
            e_mw = l_mw & ~p_mw;
            e_mr = l_mr & ~p_mr;
            e_zr = l_zr & ~p_zr;
            e_zw = l_zw & ~p_zw;
            for (int k = 0; k < 2; k++) begin
                clr = e_zw | ((k == 1) & e_zr);
                if (e_mw && m_pend[k]) m_ovr[k] = 1'b1;
                else if (e_mr)         m_ovr[k] = 1'b0;
                if (e_mw)              m_pend[k] = 1'b1;
                else if (clr)          m_pend[k] = 1'b0;
            end
            if (e_mw) begin
                m_latch   = bus0.m68k_din[7:0];
                nmi_until = cyc + NMI_W;
            end
            p_mw = l_mw; p_mr = l_mr; p_zr = l_zr; p_zw = l_zw;
        end
    end

    // Compare both instances with the model on every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("nmi_n0",  {15'd0, bus0.z80_nmi_n}, {15'd0, ~(cyc < nmi_until)});
            check("nmi_n1",  {15'd0, bus1.z80_nmi_n}, {15'd0, ~(cyc < nmi_until)});
            check("zdout0",  {8'd0, bus0.z80_dout},   {8'd0, m_latch});
            check("zdout1",  {8'd0, bus1.z80_dout},   {8'd0, m_latch});
            check("mdout0",  bus0.m68k_dout,          {14'd0, m_ovr[0], m_pend[0]});
            check("mdout1",  bus1.m68k_dout,          {14'd0, m_ovr[1], m_pend[1]});
            check("pend0",   {15'd0, bus0.pending},   {15'd0, m_pend[0]});
            check("pend1",   {15'd0, bus1.pending},   {15'd0, m_pend[1]});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change only at the negative edge.
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus0.m68k_latch_cs = 1'b0;
        bus0.m68k_sound_cs = 1'b0;
        bus0.m68k_lds_n    = 1'b1;
        bus0.m68k_din      = 16'h0000;
        bus0.z80_latch_cs  = 1'b0;
        bus0.z80_rd_n      = 1'b1;
        bus0.z80_wr_n      = 1'b1;
    endtask

    task automatic rand_inputs(input bit exclusive_m68k);
        int sel;
        sel = int'($urandom_range(0, 3));
        bus0.m68k_latch_cs = (sel == 0);
        bus0.m68k_sound_cs = exclusive_m68k ? (sel == 1) : 1'($urandom);
        bus0.m68k_lds_n    = ($urandom_range(0, 3) == 0);
        bus0.m68k_din      = 16'($urandom);
        bus0.z80_latch_cs  = 1'($urandom);
        bus0.z80_rd_n      = 1'($urandom);
        bus0.z80_wr_n      = ($urandom_range(0, 2) != 0);
    endtask

    task automatic m68k_write(input logic [7:0] b);
        bus0.m68k_latch_cs = 1'b1;
        bus0.m68k_lds_n    = 1'b0;
        bus0.m68k_din      = {8'hEE, b};
        tick();
        idle();
        tick();
    endtask

    task automatic z80_write();
        bus0.z80_latch_cs = 1'b1;
        bus0.z80_wr_n     = 1'b0;
        tick();
        idle();
        tick();
    endtask

    task automatic z80_read();
        bus0.z80_latch_cs = 1'b1;
        bus0.z80_rd_n     = 1'b0;
        tick();
        idle();
        tick();
    endtask

    task automatic m68k_status(output logic [15:0] v);
        bus0.m68k_sound_cs = 1'b1;
        v = bus0.m68k_dout;
        tick();
        idle();
        tick();
    endtask

    logic [15:0] st;
    int          lows;

    initial begin
        idle();
        reset_n = 1'b0;

        // Reset with random inputs
        rand_inputs(1'b0);
        tick();
        chk_en = 1'b1;
        rand_inputs(1'b0);
        tick();
        check("rst_nmi",   {15'd0, bus0.z80_nmi_n}, 16'h0001);
        check("rst_pend",  {15'd0, bus0.pending},   16'h0000);
        check("rst_mdout", bus0.m68k_dout,          16'h0000);
        check("rst_zdout", {8'd0, bus0.z80_dout},   16'h0000);
        idle();
        tick();
        reset_n = 1'b1;
        tick();

        // Command: select held 4 cycles gives one 16-cycle pulse
        bus0.m68k_latch_cs = 1'b1;
        bus0.m68k_lds_n    = 1'b0;
        bus0.m68k_din      = 16'h00A5;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (i == 3) idle();
            if (i == 0) begin
                check("cmd_zdout", {8'd0, bus0.z80_dout}, 16'h00A5);
                check("cmd_pend",  {15'd0, bus0.pending}, 16'h0001);
                check("cmd_nmi0",  {15'd0, bus0.z80_nmi_n}, 16'h0000);
            end
            if (i == 16) check("cmd_nmi_end", {15'd0, bus0.z80_nmi_n}, 16'h0001);
            if (!bus0.z80_nmi_n) lows++;
        end
        check("cmd_lows", 16'(lows), 16'd16);

        // Clear by Z80 write, then a Z80 read leaves pending alone when CLEAR_ON_READ=0
        z80_write();
        check("clr_pend",  {15'd0, bus0.pending},   16'h0000);
        check("clr_zdout", {8'd0, bus0.z80_dout},   16'h00A5);
        m68k_write(8'h5A);
        z80_read();
        check("rd_pend0",  {15'd0, bus0.pending},   16'h0001);
        check("rd_pend1",  {15'd0, bus1.pending},   16'h0000);
        check("rd_zdout",  {8'd0, bus0.z80_dout},   16'h005A);
        z80_write();

        // Upper-byte-only write is ignored
        bus0.m68k_latch_cs = 1'b1;
        bus0.m68k_lds_n    = 1'b1;
        bus0.m68k_din      = 16'h7777;
        tick();
        idle();
        tick();
        check("ub_zdout", {8'd0, bus0.z80_dout},   16'h005A);
        check("ub_mdout", bus0.m68k_dout,          16'h0000);

        // Overrun
        m68k_write(8'h11);
        m68k_write(8'h22);
        check("ovr_zdout", {8'd0, bus0.z80_dout}, 16'h0022);
        check("ovr_mdout", bus0.m68k_dout,        16'h0003);
        m68k_status(st);
        check("ovr_rd1", st, 16'h0003);
        m68k_status(st);
        check("ovr_rd2", st, 16'h0001);

        // Race: M68K write and Z80 clear in the same cycle, write wins
        bus0.m68k_latch_cs = 1'b1;
        bus0.m68k_lds_n    = 1'b0;
        bus0.m68k_din      = 16'h0033;
        bus0.z80_latch_cs  = 1'b1;
        bus0.z80_wr_n      = 1'b0;
        tick();
        idle();
        check("race_pend",  {15'd0, bus0.pending}, 16'h0001);
        check("race_zdout", {8'd0, bus0.z80_dout}, 16'h0033);
        repeat (20) tick();

        // Reload: second write 5 cycles into the pulse gives 5+16 low cycles
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 0 || i == 5) begin
                bus0.m68k_latch_cs = 1'b1;
                bus0.m68k_lds_n    = 1'b0;
                bus0.m68k_din      = (i == 0) ? 16'h0044 : 16'h0055;
            end
            tick();
            idle();
            if (!bus0.z80_nmi_n) lows++;
        end
        check("reload_lows", 16'(lows), 16'd21);

        // Reset 8 cycles into a pulse
        bus0.m68k_latch_cs = 1'b1;
        bus0.m68k_lds_n    = 1'b0;
        bus0.m68k_din      = 16'h0066;
        tick();
        idle();
        repeat (7) tick();
        check("mid_nmi_pre", {15'd0, bus0.z80_nmi_n}, 16'h0000);
        reset_n = 1'b0;
        tick();
        check("mid_nmi",  {15'd0, bus0.z80_nmi_n}, 16'h0001);
        check("mid_pend", {15'd0, bus0.pending},   16'h0000);
        reset_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus0.z80_nmi_n) lows++;
        end
        check("mid_no_resume", 16'(lows), 16'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 399) != 0);
            rand_inputs(1'b1);
            tick();
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
